// File: rtl/csi_pkg.sv
// csi_pkg: shared types and constants for the CSI-2 line writer.
//   state_e      - line writer FSM state encoding
//   WPL_DEFAULT  - default payload words per line (640 RAW8 bytes)
//   LPF_DEFAULT  - default lines per frame
//   PT_*         - CSI-2 packet data types seen by the upstream decoder
package csi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DROP  = 3'd3,
    ST_TAIL  = 3'd4
  } state_e;

  localparam int WPL_DEFAULT = 160;
  localparam int LPF_DEFAULT = 480;

  localparam logic [7:0] PT_FS   = 8'h00;
  localparam logic [7:0] PT_FE   = 8'h01;
  localparam logic [7:0] PT_RAW8 = 8'h2A;

endpackage

// File: rtl/line_bank_ram.sv
// line_bank_ram: two-bank line store, simple dual port.
//   mipi_clk_8  - clock
//   reset_n     - async active-low reset (read register only)
//   we_i        - write enable
//   waddr_i     - write address {bank, word}
//   wdata_i     - write data
//   raddr_i     - read address {bank, word}
//   rdata_o     - registered read data, 1-cycle latency
// The array spans the full {bank, word} address space; words at or beyond
// the line length are never written and read back as don't-care.
module line_bank_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              mipi_clk_8,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [ADDR_W:0]   waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W:0]   raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [2**(ADDR_W+1)];

  // No reset on the array so it maps onto block RAM; a same-address read
  // during a write returns the previous contents.
  always_ff @(posedge mipi_clk_8) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge mipi_clk_8 or negedge reset_n) begin
    if (!reset_n) rdata_o <= '0;
    else          rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/csi_line_writer.sv
// csi_line_writer: captures CSI-2 RAW8 payload lines into a ping-pong line
// buffer and hands completed lines to the reader.
//   mipi_clk_8, reset_n          - clock, async active-low reset
//   fs                           - frame-start pulse
//   word_valid, word_data        - payload word stream
//   line_ready, line_bank, line_num - commit pulse and held line info
//   rd_bank, rd_addr, rd_data    - synchronous read port (1-cycle latency)
//   rd_done                      - reader releases bank rd_bank
//   frame_done                   - pulse after the last line of a frame
//   overflow, short_line         - sticky errors, cleared by clear_err
//
// state | meaning
// IDLE  | no frame active, payload ignored until fs
// ARM   | waiting for the rising edge of word_valid (start of a line)
// WRITE | storing words of the current line
// DROP  | target bank full, discarding the line
// TAIL  | line committed, discarding excess words until word_valid falls
module csi_line_writer import csi_pkg::*; #(
  parameter int WORDS_PER_LINE  = WPL_DEFAULT,
  parameter int LINES_PER_FRAME = LPF_DEFAULT,
  parameter int ADDR_W          = 8
) (
  input  logic              mipi_clk_8,
  input  logic              reset_n,
  input  logic              fs,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              line_ready,
  output logic              line_bank,
  output logic [15:0]       line_num,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              rd_done,
  output logic              frame_done,
  output logic              overflow,
  output logic              short_line,
  input  logic              clear_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic [15:0]       LPF16     = 16'(LINES_PER_FRAME);

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       line_cnt_q, line_cnt_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              vld_prev_q;
  logic              commit, we, ovf_set, short_set, frame_end;
  logic              vld_rise;

  assign vld_rise = word_valid & ~vld_prev_q;

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    line_cnt_d = line_cnt_q;
    commit     = 1'b0;
    we         = 1'b0;
    ovf_set    = 1'b0;
    short_set  = 1'b0;
    frame_end  = 1'b0;
    // fs wins over everything, including a pending frame end
    if (fs) begin
      state_d    = ST_ARM;
      line_cnt_d = '0;
      wr_addr_d  = '0;
      wr_bank_d  = 1'b0;
    end else if (state_q != ST_IDLE && line_cnt_q == LPF16) begin
      frame_end = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ARM: begin
          if (vld_rise) begin
            if (bank_full_q[wr_bank_q]) begin
              ovf_set = 1'b1;
              state_d = ST_DROP;
            end else begin
              we        = 1'b1;
              wr_addr_d = ADDR_W'(1);
              state_d   = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (word_valid) begin
            we = 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
              commit     = 1'b1;
              wr_bank_d  = ~wr_bank_q;
              wr_addr_d  = '0;
              line_cnt_d = line_cnt_q + 16'd1;
              state_d    = ST_TAIL;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
          end else begin
            short_set  = 1'b1;
            line_cnt_d = line_cnt_q + 16'd1;
            wr_addr_d  = '0;
            state_d    = ST_ARM;
          end
        end
        ST_DROP: begin
          if (!word_valid) begin
            line_cnt_d = line_cnt_q + 16'd1;
            state_d    = ST_ARM;
          end
        end
        ST_TAIL: begin
          if (!word_valid) state_d = ST_ARM;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Release first, then commit: a commit is never aimed at a full bank, so
  // overlapping set/clear on the same bank cannot lose a committed line.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_done) bank_full_d = bank_full_d & ~(2'b01 << rd_bank);
    if (commit)  bank_full_d = bank_full_d |  (2'b01 << wr_bank_q);
  end

  always_ff @(posedge mipi_clk_8 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      line_cnt_q  <= '0;
      bank_full_q <= 2'b00;
      vld_prev_q  <= 1'b0;
      line_ready  <= 1'b0;
      line_bank   <= 1'b0;
      line_num    <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      short_line  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      line_cnt_q  <= line_cnt_d;
      bank_full_q <= bank_full_d;
      vld_prev_q  <= word_valid;
      line_ready  <= commit;
      frame_done  <= frame_end;
      if (commit) begin
        line_bank <= wr_bank_q;
        line_num  <= line_cnt_q;
      end
      overflow   <= clear_err ? 1'b0 : (overflow   | ovf_set);
      short_line <= clear_err ? 1'b0 : (short_line | short_set);
    end
  end

  line_bank_ram #(.ADDR_W(ADDR_W)) u_ram (
    .mipi_clk_8 (mipi_clk_8),
    .reset_n    (reset_n),
    .we_i       (we),
    .waddr_i    ({wr_bank_q, wr_addr_q}),
    .wdata_i    (word_data),
    .raddr_i    ({rd_bank, rd_addr}),
    .rdata_o    (rd_data)
  );

endmodule

// File: tb/tb_csi_line_writer.sv
// tb_csi_line_writer: scoreboard bench for csi_line_writer (4 lines/frame).
module tb_csi_line_writer;

  localparam int WPL    = 160;
  localparam int LPF    = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fs, word_valid, rd_bank, rd_done, clear_err;
  logic [31:0]       word_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              line_ready, line_bank, frame_done, overflow, short_line;
  logic [15:0]       line_num;
  logic [31:0]       rd_data;

  typedef struct packed {
    logic        bank;
    logic [15:0] num;
  } commit_t;

  commit_t     exp_q[$];
  logic [31:0] rd_exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          fd_cnt = 0;
  int          fd0;

  always #5 clk = ~clk;

  csi_line_writer #(
    .WORDS_PER_LINE (WPL),
    .LINES_PER_FRAME(LPF),
    .ADDR_W         (ADDR_W)
  ) dut (
    .mipi_clk_8 (clk),
    .reset_n    (rst_n),
    .fs         (fs),
    .word_valid (word_valid),
    .word_data  (word_data),
    .line_ready (line_ready),
    .line_bank  (line_bank),
    .line_num   (line_num),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .frame_done (frame_done),
    .overflow   (overflow),
    .short_line (short_line),
    .clear_err  (clear_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic release_bank(input logic b);
    rd_bank = b;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  // n words base+i, then a gap; optionally checks line_ready right after word WPL-1
  task automatic send_line(input int n, input logic [31:0] base, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      word_valid = 1'b1;
      word_data  = base + 32'(i);
      tick();
      if (chk_lat && i == WPL - 1) check("ready_lat", {63'd0, line_ready}, 64'd1);
    end
    word_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic read_bank(input logic b, input logic [31:0] base, input int n);
    logic [31:0] e;
    for (int a = 0; a < n; a++) begin
      rd_bank = b;
      rd_addr = ADDR_W'(a);
      rd_exp_q.push_back(base + 32'(a));
      tick();
      e = rd_exp_q.pop_front();
      check("rd_data", {32'd0, rd_data}, {32'd0, e});
    end
  endtask

  always @(negedge clk) begin
    commit_t e;
    if (rst_n && line_ready) begin
      if (exp_q.size() == 0) begin
        check("unexp_commit", {63'd0, line_ready}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("commit_bank", {63'd0, line_bank}, {63'd0, e.bank});
        check("commit_num", {48'd0, line_num}, {48'd0, e.num});
      end
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fs = 1'b0; word_valid = 1'b0; word_data = '0;
    rd_bank = 1'b0; rd_addr = '0; rd_done = 1'b0; clear_err = 1'b0;
    repeat (3) tick();
    check("rst_line_ready", {63'd0, line_ready}, 64'd0);
    check("rst_line_bank",  {63'd0, line_bank},  64'd0);
    check("rst_line_num",   {48'd0, line_num},   64'd0);
    check("rst_rd_data",    {32'd0, rd_data},    64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_overflow",   {63'd0, overflow},   64'd0);
    check("rst_short_line", {63'd0, short_line}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // one full line and readback
    pulse_fs();
    exp_q.push_back('{bank: 1'b0, num: 16'd0});
    send_line(WPL, 32'h0A000000, 1'b1);
    read_bank(1'b0, 32'h0A000000, WPL);
    release_bank(1'b0);

    // both banks full, third line overflows, release bank 0, fourth commits
    pulse_fs();
    fd0 = fd_cnt;
    exp_q.push_back('{bank: 1'b0, num: 16'd0});
    send_line(WPL, 32'h1B000000, 1'b1);
    exp_q.push_back('{bank: 1'b1, num: 16'd1});
    send_line(WPL, 32'h1C000000, 1'b1);
    check("ovf_before", {63'd0, overflow}, 64'd0);
    send_line(WPL, 32'h1D000000, 1'b0);
    check("ovf_set", {63'd0, overflow}, 64'd1);
    release_bank(1'b0);
    exp_q.push_back('{bank: 1'b0, num: 16'd3});
    send_line(WPL, 32'h1E000000, 1'b1);
    repeat (10) tick();
    check("hold_line_bank", {63'd0, line_bank}, 64'd0);
    check("hold_line_num",  {48'd0, line_num},  64'd3);
    check("fd_after_ovf",   64'(fd_cnt - fd0),  64'd1);
    release_bank(1'b0);
    release_bank(1'b1);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);
    pulse_clear();
    check("ovf_clear", {63'd0, overflow}, 64'd0);

    // short line, then a full line to bank 0 as line 1
    pulse_fs();
    send_line(100, 32'h2A000000, 1'b0);
    check("short_set", {63'd0, short_line}, 64'd1);
    exp_q.push_back('{bank: 1'b0, num: 16'd1});
    send_line(WPL, 32'h2B000000, 1'b1);
    check("short_sticky", {63'd0, short_line}, 64'd1);
    pulse_clear();
    check("short_clear", {63'd0, short_line}, 64'd0);
    release_bank(1'b0);

    // full frame with releases, then payload ignored until fs
    pulse_fs();
    fd0 = fd_cnt;
    for (int l = 0; l < LPF; l++) begin
      exp_q.push_back('{bank: 1'(l % 2), num: 16'(l)});
      send_line(WPL, 32'h30000000 + 32'(l << 16), 1'b1);
      release_bank(1'(l % 2));
    end
    repeat (4) tick();
    check("fd_once", 64'(fd_cnt - fd0), 64'd1);
    send_line(WPL, 32'h3F000000, 1'b0);
    check("fd_idle", 64'(fd_cnt - fd0), 64'd1);

    // fs mid-line after 50 words: silent restart
    pulse_fs();
    for (int i = 0; i < 50; i++) begin
      word_valid = 1'b1;
      word_data  = 32'h4A000000 + 32'(i);
      tick();
    end
    fs = 1'b1;
    word_data = 32'h4A000032;
    tick();
    fs = 1'b0;
    word_valid = 1'b0;
    repeat (4) tick();
    check("fs_mid_short", {63'd0, short_line}, 64'd0);
    check("fs_mid_ovf",   {63'd0, overflow},   64'd0);
    exp_q.push_back('{bank: 1'b0, num: 16'd0});
    send_line(WPL, 32'h5A000000, 1'b1);

    // 170-word burst into bank 1, excess words ignored
    exp_q.push_back('{bank: 1'b1, num: 16'd1});
    send_line(WPL + 10, 32'h6B000000, 1'b1);
    read_bank(1'b1, 32'h6B000000, 10);
    read_bank(1'b0, 32'h5A000000, 10);
    check("burst_short", {63'd0, short_line}, 64'd0);

    repeat (10) tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/csi_line_writer.md
Name: csi_line_writer

Overview:
- Downstream stage of the CSI-2 packet decoder.
- Consumes its per-line payload stream: 32-bit words, qualified by a level-valid strobe, each word carrying 4 RAW8 pixels.
- Captures each line into a two-bank (ping-pong) line buffer and tracks line and frame position.
- Hands completed lines to the frame-RAM/display side through a bank-ready/bank-release handshake with a synchronous read port.

Parameters:
- WORDS_PER_LINE, 160, payload words per line (640 RAW8 bytes).
- LINES_PER_FRAME, 480, lines expected after frame start.
- ADDR_W, 8, word address width within one bank; must satisfy 2^ADDR_W >= WORDS_PER_LINE.

Ports:
- mipi_clk_8  in  1  sole clock (payload word clock).
- reset_n  in  1  asynchronous, active-low reset.
- fs  in  1  one-cycle frame-start pulse (short packet type 0x00).
- word_valid  in  1  high for each cycle word_data holds a payload word; contiguous per line.
- word_data  in  32  payload word, byte 0 in [7:0].
- line_ready  out  1  one-cycle pulse: a line was committed to bank line_bank.
- line_bank  out  1  bank index of the committed line; held until the next commit.
- line_num  out  16  line index of the committed line, 0-based; held.
- rd_bank  in  1  read bank select.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  32  read word; 1-cycle latency.
- rd_done  in  1  one-cycle pulse: the reader releases bank rd_bank.
- frame_done  out  1  one-cycle pulse after line LINES_PER_FRAME-1 is processed.
- overflow  out  1  sticky: a line arrived while its target bank was still full.
- short_line  out  1  sticky: word_valid fell before WORDS_PER_LINE words arrived.
- clear_err  in  1  synchronous clear of overflow and short_line.

Behaviour:
- Reset values (async assert, sync release):
  - Outputs: line_ready=0, line_bank=0, line_num=0, rd_data=0, frame_done=0, overflow=0, short_line=0.
  - Internals: wr_bank=0, wr_addr=0, line_cnt=0, bank_full=2'b00, state=IDLE.
- FSM states: IDLE, ARM, WRITE, DROP, TAIL.
- IDLE: word_valid ignored; fs -> ARM with line_cnt=0, wr_bank=0, wr_addr=0.
- ARM: waits for a word_valid rising edge.
  - If bank_full[wr_bank]=1: set overflow and go to DROP. The rising-edge word is discarded.
  - Otherwise go to WRITE. The rising-edge word is written at addr 0, so wr_addr=1 on entry.
- WRITE: each word_valid=1 cycle writes mem[wr_bank][wr_addr] and increments wr_addr.
  - The write of word WORDS_PER_LINE-1 commits the line:
    - bank_full[wr_bank] set.
    - Next cycle: line_ready=1, line_bank=old wr_bank, line_num=line_cnt.
    - wr_bank toggles, wr_addr=0, line_cnt increments; go to TAIL.
  - word_valid=0 before the commit: set short_line; the line is discarded (bank_full unchanged, wr_bank unchanged); line_cnt increments, wr_addr=0; go to ARM.
- DROP: ignore words while word_valid=1; when it falls, increment line_cnt and go to ARM.
- TAIL: ignore excess words until word_valid=0, then go to ARM.
- Frame end: when line_cnt reaches LINES_PER_FRAME on any path, pulse frame_done one cycle later and go to IDLE.
- fs in any non-IDLE state restarts the frame: line_cnt=0, wr_addr=0, wr_bank=0, state=ARM. A partial line in progress is discarded silently (no short_line). bank_full is not touched.
- rd_done clears bank_full[rd_bank].
  - A same-cycle commit to the other bank applies both changes.
  - rd_done to an empty bank is a no-op.
- Read port: rd_data is registered from mem[rd_bank][rd_addr] every cycle, with no enable.
  - Read-during-write to the same location returns old data.
  - Addresses >= WORDS_PER_LINE return undefined data and must not be checked.
- clear_err has priority over a same-cycle set of either error flag.
- line_cnt is 16 bits; LINES_PER_FRAME <= 65535.

Decomposition:
- Shared package csi_pkg:
  - FSM state enum.
  - Default WORDS_PER_LINE / LINES_PER_FRAME.
  - Packet type constants 0x00 (FS), 0x01 (FE), 0x2A (RAW8).
- Sub-module line_bank_ram: 2*WORDS_PER_LINE x 32 simple dual-port memory. Address = {bank, addr}. One write port, one registered read port. Must infer block RAM.

Test Plan:
- Reset, fs, then one line of 160 words, word i = 32'h0A000000+i -> line_ready once, 1 cycle after word 159, line_bank=0, line_num=0; bank 0 rd_addr 0..159 reads back 0A000000..0A00009F one cycle after each address.
- Two lines with no rd_done, then a third line -> lines 0 and 1 committed to banks 0 and 1; third line sets overflow, no line_ready; line_num of the next commit = 3 after rd_done on bank 0.
- fs, word_valid high for 100 words, then low -> short_line=1, no line_ready; next full line commits to bank 0 with line_num=1; clear_err -> short_line=0.
- LINES_PER_FRAME=4, four full lines with rd_done after each -> line_num 0,1,2,3 on banks 0,1,0,1; frame_done pulses once; further words ignored until the next fs.
- fs asserted mid-line after 50 words -> no flags set; next full line commits line_num=0, bank 0.
- 170-word burst -> commit after word 159, words 160-169 ignored, exactly one line_ready.
